// File: rtl/seq_mult_32b.sv
// seq_mult_32b: iterative shift-add multiplier producing a signed or unsigned
// 2*WIDTH-bit product in the hi/lo register pair, one bit of multiplier per cycle.
module seq_mult_32b #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mplr;
  logic             neg;

  logic             accept;
  logic             last_iter;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   lo_neg;
  logic [WIDTH-1:0] hi_neg;
  logic [WIDTH-1:0] fix_hi;
  logic [WIDTH-1:0] fix_lo;

  assign accept    = start && ((state == IDLE) || (state == DONE));
  assign last_iter = (count == CW'(WIDTH - 1));

  // The most negative value maps onto itself, which reads correctly as an unsigned magnitude.
  assign mag_a = (is_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
  assign mag_b = (is_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;

  assign sum = {1'b0, acc} + (mplr[0] ? {1'b0, mcand} : {(WIDTH + 1){1'b0}});

  // Two's complement of {acc,mplr}, carrying out of the low half into the high half.
  assign lo_neg = {1'b0, ~mplr} + (WIDTH + 1)'(1);
  assign hi_neg = ~acc + WIDTH'(lo_neg[WIDTH]);
  assign fix_hi = neg ? hi_neg : acc;
  assign fix_lo = neg ? lo_neg[WIDTH-1:0] : mplr;

  assign busy = (state == RUN) || (state == FIX);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_iter) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      mcand <= '0;
      acc   <= '0;
      mplr  <= '0;
      neg   <= 1'b0;
    end else if (accept) begin
      count <= '0;
      mcand <= mag_a;
      acc   <= '0;
      mplr  <= mag_b;
      neg   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
    end else if (state == RUN) begin
      count <= count + CW'(1);
      acc   <= sum[WIDTH:1];
      mplr  <= {sum[0], mplr[WIDTH-1:1]};
    end
  end

  // Result registers update only when a product completes, so partial sums never leak out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi   <= '0;
      lo   <= '0;
      zero <= 1'b0;
    end else if (state == FIX) begin
      hi   <= fix_hi;
      lo   <= fix_lo;
      zero <= ~|{fix_hi, fix_lo};
    end
  end

endmodule

// File: tb/tb_seq_mult_32b.sv
// Self-checking bench for seq_mult_32b: directed corner cases plus random
// operands compared against a plain 64-bit arithmetic reference product.
module tb_seq_mult_32b;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        zero;

  int checks;
  int failures;

  seq_mult_32b #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] refProd(input logic [31:0] x, input logic [31:0] y,
                                          input logic s);
    logic signed [63:0] ex;
    logic signed [63:0] ey;
    if (s) begin
      ex = {{32{x[31]}}, x};
      ey = {{32{y[31]}}, y};
    end else begin
      ex = {32'b0, x};
      ey = {32'b0, y};
    end
    return 64'(ex * ey);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issues one operation and checks latency, busy length, result and the single-cycle done.
  task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv, input logic sv,
                               input string tag);
    logic [63:0] exp;
    int done_at;
    int busy_cnt;
    exp      = refProd(av, bv, sv);
    done_at  = 0;
    busy_cnt = 0;
    @(negedge clk);
    a = av; b = bv; is_signed = sv; start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin
        done_at = k;
        break;
      end
    end
    checkOutput({tag, "_lat"}, 64'(done_at), 64'd34);
    checkOutput({tag, "_busy"}, 64'(busy_cnt), 64'd33);
    checkOutput({tag, "_hi"}, {32'b0, hi}, {32'b0, exp[63:32]});
    checkOutput({tag, "_lo"}, {32'b0, lo}, {32'b0, exp[31:0]});
    checkOutput({tag, "_zero"}, {63'b0, zero}, {63'b0, (exp == 64'd0)});
    @(negedge clk);
    checkOutput({tag, "_pulse"}, {63'b0, done}, 64'd0);
  endtask

  initial begin
    int done_cnt;
    int done_at;
    logic [63:0] exp;
    logic        ok_hold;
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    is_signed = 1'b0;
    a         = '0;
    b         = '0;

    #1;
    checkOutput("rst_busy", {63'b0, busy}, 64'd0);
    checkOutput("rst_done", {63'b0, done}, 64'd0);
    checkOutput("rst_hilo", {hi, lo}, 64'd0);
    checkOutput("rst_zero", {63'b0, zero}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "umax");
    applyStimulus(32'hFFFF_FFFD, 32'd5, 1'b1, "neg3x5");
    applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b1, "minxmin");
    applyStimulus(32'h8000_0000, 32'd1, 1'b1, "minx1");
    applyStimulus(32'h0, 32'h1234_5678, 1'b0, "zero_u");
    applyStimulus(32'h0, 32'h1234_5678, 1'b1, "zero_s");
    applyStimulus(32'd2, 32'd3, 1'b0, "two_three");

    // Idle with toggling operands: result registers must hold 2*3.
    exp = refProd(32'd2, 32'd3, 1'b0);
    done_cnt = 0;
    ok_hold  = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      a = $urandom; b = $urandom; is_signed = 1'($urandom);
      if ({hi, lo} !== exp || zero !== 1'b0) ok_hold = 1'b0;
      if (done) done_cnt++;
    end
    checkOutput("hold_stable", {63'b0, ok_hold}, 64'd1);
    checkOutput("hold_no_done", 64'(done_cnt), 64'd0);

    // Start during busy is ignored; start held on the done cycle is accepted.
    @(negedge clk);
    a = 32'd7; b = 32'd9; is_signed = 1'b0; start = 1'b1;
    done_cnt = 0;
    done_at  = 0;
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 4) begin
        a = 32'd100; b = 32'd100; start = 1'b1;
      end
      if (done) begin
        done_cnt++;
        done_at = k;
      end
    end
    checkOutput("b2b_first_at", 64'(done_at), 64'd34);
    checkOutput("b2b_first_cnt", 64'(done_cnt), 64'd1);
    checkOutput("b2b_first_res", {hi, lo}, refProd(32'd7, 32'd9, 1'b0));
    a = 32'd4; b = 32'd4; start = 1'b1;
    done_cnt = 0;
    done_at  = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 1) checkOutput("b2b_busy_again", {63'b0, busy}, 64'd1);
      if (k == 10) checkOutput("b2b_hold_prev", {hi, lo}, refProd(32'd7, 32'd9, 1'b0));
      if (done) begin
        done_cnt++;
        if (done_at == 0) done_at = k;
      end
    end
    checkOutput("b2b_second_at", 64'(done_at), 64'd34);
    checkOutput("b2b_second_cnt", 64'(done_cnt), 64'd1);
    checkOutput("b2b_second_res", {hi, lo}, refProd(32'd4, 32'd4, 1'b0));

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    a = 32'h1234; b = 32'h5678; is_signed = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_busy", {63'b0, busy}, 64'd0);
    checkOutput("mid_rst_done", {63'b0, done}, 64'd0);
    checkOutput("mid_rst_hilo", {hi, lo}, 64'd0);
    checkOutput("mid_rst_zero", {63'b0, zero}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    checkOutput("mid_rst_no_done", 64'(done_cnt), 64'd0);
    applyStimulus(32'd6, 32'd7, 1'b0, "post_rst");

    for (int i = 0; i < 16; i++) begin
      applyStimulus($urandom, $urandom, 1'($urandom), $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
